// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the stream cipher transmit and receive paths.
// Keystream is a 16-bit right-shifting Galois LFSR; its low byte is the key byte.
package stream_cipher_pkg;

   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [15:0] LFSR_ZERO_SEED = 16'h0001;

   typedef enum logic [1:0] {
      HUNT,
      IV_HI,
      IV_LO,
      PAYLOAD
   } rx_state_e;

   function automatic logic [15:0] lfsr_step(logic [15:0] value);
      logic [15:0] shifted;
      shifted = value >> 1;
      return value[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

   // An all-zero LFSR would lock up, so a zero seed is replaced.
   function automatic logic [15:0] seed_fix(logic [15:0] seed);
      return (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
   endfunction

endpackage

// File: rtl/stream_keystream_gen.sv
// Keystream generator shared by the cipher transmit and receive paths.
// load reseeds the LFSR (zero seed replaced), adv steps it once; ks is the current key byte.
module stream_keystream_gen
   import stream_cipher_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        adv,
   output logic [7:0]  ks
);

   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_ZERO_SEED;
      end else if (load) begin
         lfsr <= seed_fix(seed);
      end else if (adv) begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   assign ks = lfsr[7:0];

endmodule

// File: rtl/stream_decipher_rx.sv
// Receive-side stream decipher: hunts SYNC, captures a 16-bit IV, decrypts FRAME_LEN bytes.
// Optional macro STREAM_RX_CHECK_EN turns the final payload byte into an XOR check byte (crc_err).
module stream_decipher_rx
   import stream_cipher_pkg::*;
#(
   parameter logic [15:0] KEY       = 16'hACE1,
   parameter logic [7:0]  SYNC      = 8'hA5,
   parameter int          FRAME_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       busy,
   output logic [7:0] frame_cnt
`ifdef STREAM_RX_CHECK_EN
   ,
   output logic       crc_err
`endif
);

   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   rx_state_e   state;
   rx_state_e   state_next;
   logic [7:0]  iv_hi;
   logic [7:0]  byte_cnt;
   logic [7:0]  ks;
   logic [7:0]  plain;
   logic        accept;
   logic        emit;
   logic        payload_acc;
   logic        final_byte;
   logic        data_byte;
   logic        data_last;
   logic        ks_load;

   assign in_ready    = (state != PAYLOAD) || !out_valid || out_ready;
   assign accept      = in_valid && in_ready;
   assign emit        = out_valid && out_ready;
   assign payload_acc = accept && (state == PAYLOAD);
   assign final_byte  = payload_acc && (byte_cnt == LAST_IDX);
   assign ks_load     = accept && (state == IV_LO);
   assign plain       = in_data ^ ks;
   assign busy        = (state != HUNT);

`ifdef STREAM_RX_CHECK_EN
   localparam logic [7:0] LAST_DATA_IDX = 8'(FRAME_LEN - 2);

   // The check byte is consumed but never emitted, so the last data byte carries out_last.
   assign data_byte = payload_acc && !final_byte;
   assign data_last = (byte_cnt == LAST_DATA_IDX);
`else
   assign data_byte = payload_acc;
   assign data_last = (byte_cnt == LAST_IDX);
`endif

   stream_keystream_gen u_keystream (
      .clk  (clk),
      .rst  (rst),
      .load (ks_load),
      .seed (KEY ^ {iv_hi, in_data}),
      .adv  (payload_acc),
      .ks   (ks)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         HUNT:    if (accept && (in_data == SYNC)) state_next = IV_HI;
         IV_HI:   if (accept) state_next = IV_LO;
         IV_LO:   if (accept) state_next = PAYLOAD;
         PAYLOAD: if (final_byte) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   // A new data byte overwrites the output register only when it is free or being emitted.
   always_ff @(posedge clk) begin
      if (rst) begin
         iv_hi     <= 8'h00;
         byte_cnt  <= 8'h00;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_last  <= 1'b0;
         frame_cnt <= 8'h00;
      end else begin
         if (accept && (state == IV_HI)) begin
            iv_hi <= in_data;
         end
         if (ks_load) begin
            byte_cnt <= 8'h00;
         end else if (payload_acc) begin
            byte_cnt <= byte_cnt + 8'd1;
         end
         if (final_byte) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (data_byte) begin
            out_valid <= 1'b1;
            out_data  <= plain;
            out_last  <= data_last;
         end else if (emit) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

`ifdef STREAM_RX_CHECK_EN
   logic [7:0] xor_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         xor_acc <= 8'h00;
         crc_err <= 1'b0;
      end else begin
         crc_err <= final_byte && (plain != xor_acc);
         if (ks_load) begin
            xor_acc <= 8'h00;
         end else if (data_byte) begin
            xor_acc <= xor_acc ^ plain;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_decipher_rx.sv
// Self-checking bench for stream_decipher_rx: directed cases plus randomized frames
// checked against a transmitter-style reference model (honours STREAM_RX_CHECK_EN).
module tb_stream_decipher_rx;

   localparam logic [15:0] KEY  = 16'hACE1;
   localparam logic [7:0]  SYNC = 8'hA5;
   localparam int          FL   = 2;
`ifdef STREAM_RX_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int DATA_N = CHK ? FL - 1 : FL;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic [7:0] frame_cnt;
`ifdef STREAM_RX_CHECK_EN
   logic       crc_err;
`endif

   stream_decipher_rx #(
      .KEY       (KEY),
      .SYNC      (SYNC),
      .FRAME_LEN (FL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .frame_cnt (frame_cnt)
`ifdef STREAM_RX_CHECK_EN
      ,
      .crc_err   (crc_err)
`endif
   );

   always #5 clk = ~clk;

   typedef enum int {K_JUNK, K_SYNC, K_IVH, K_IVL, K_DATA, K_CHECK} kind_e;
   typedef struct {
      logic [7:0] b;
      kind_e      kind;
      logic [7:0] pt;
      logic       last;
      logic       fin;
      logic       bad;
   } ent_t;
   typedef struct {
      logic [7:0] pt;
      logic       last;
   } out_t;

   ent_t       stream[$];
   out_t       expq[$];
   logic [7:0] emitted[$];
   int         phase;
   logic [7:0] expFrames;
   logic       crcExp;
   int         totalChecks = 0;
   int         badChecks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Galois right-shift LFSR step, written arithmetically.
   function automatic logic [15:0] nextKs(input logic [15:0] s);
      if (s % 2 == 1) return (s / 2) ^ 16'hB400;
      return s / 2;
   endfunction

   task automatic pushEnt(input logic [7:0] b, input kind_e kind, input logic [7:0] pt,
                          input logic last, input logic fin, input logic bad);
      ent_t e;
      e.b = b; e.kind = kind; e.pt = pt; e.last = last; e.fin = fin; e.bad = bad;
      stream.push_back(e);
   endtask

   // Acts as the transmitter: builds header + ciphertext and records the plaintext it implies.
   task automatic addFrame(input logic [15:0] iv, input int nJunk, input logic [7:0] c0,
                           input logic [7:0] c1, input bit randomCt, input logic [7:0] checkErr);
      logic [15:0] ks;
      logic [7:0]  c, p, acc, jb;
      for (int j = 0; j < nJunk; j++) begin
         jb = 8'($urandom_range(255));
         if (jb == SYNC) jb = 8'h00;
         pushEnt(jb, K_JUNK, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      pushEnt(SYNC, K_SYNC, 8'h00, 1'b0, 1'b0, 1'b0);
      pushEnt(iv[15:8], K_IVH, 8'h00, 1'b0, 1'b0, 1'b0);
      pushEnt(iv[7:0], K_IVL, 8'h00, 1'b0, 1'b0, 1'b0);
      ks = KEY ^ iv;
      if (ks == 16'h0000) ks = 16'h0001;
      acc = 8'h00;
      for (int i = 0; i < DATA_N; i++) begin
         if (randomCt || i > 1) c = 8'($urandom_range(255));
         else c = (i == 0) ? c0 : c1;
         p = c ^ ks[7:0];
         acc = acc ^ p;
         pushEnt(c, K_DATA, p, i == DATA_N - 1, (i == DATA_N - 1) && !CHK, 1'b0);
         ks = nextKs(ks);
      end
      if (CHK) begin
         p = acc ^ checkErr;
         pushEnt(p ^ ks[7:0], K_CHECK, p, 1'b0, 1'b1, checkErr != 8'h00);
      end
   endtask

   task automatic monitor();
      checkOutput("in_ready", in_ready, (phase != 3) || (expq.size() == 0) || out_ready);
      checkOutput("busy", busy, phase != 0);
      checkOutput("frame_cnt", frame_cnt, expFrames);
`ifdef STREAM_RX_CHECK_EN
      checkOutput("crc_err", crc_err, crcExp);
`endif
      checkOutput("out_valid", out_valid, expq.size() != 0);
      if (out_valid && expq.size() != 0) begin
         checkOutput("out_data", out_data, expq[0].pt);
         checkOutput("out_last", out_last, expq[0].last);
         if (out_ready) begin
            emitted.push_back(out_data);
            void'(expq.pop_front());
         end
      end
   endtask

   task automatic consume(input ent_t e);
      case (e.kind)
         K_SYNC:  phase = 1;
         K_IVH:   phase = 2;
         K_IVL:   phase = 3;
         K_DATA:  expq.push_back('{pt: e.pt, last: e.last});
         default: ;
      endcase
      if (e.fin) begin
         phase = 0;
         expFrames = expFrames + 8'd1;
         crcExp = e.bad;
      end
   endtask

   // One clock: drive at the falling edge, check just after, and book the accept for the next edge.
   task automatic applyStimulus(input bit rdy, input int idlePct);
      ent_t e;
      @(negedge clk);
      out_ready = rdy;
      if (stream.size() != 0 && int'($urandom_range(99)) >= idlePct) begin
         in_valid = 1'b1;
         in_data  = stream[0].b;
      end else begin
         in_valid = 1'b0;
         in_data  = 8'($urandom_range(255));
      end
      #1;
      monitor();
      crcExp = 1'b0;
      if (in_valid && in_ready) begin
         e = stream.pop_front();
         consume(e);
      end
   endtask

   task automatic runUntilIdle(input int maxCycles, input bit randomReady);
      int n = 0;
      while ((stream.size() != 0 || expq.size() != 0) && n < maxCycles) begin
         if (randomReady) applyStimulus($urandom_range(3) != 0, 20);
         else applyStimulus(1'b1, 0);
         n++;
      end
      checkOutput("drain_left", stream.size() + expq.size(), 0);
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_last"}, out_last, 0);
      checkOutput({tag, "_out_data"}, out_data, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
      checkOutput({tag, "_in_ready"}, in_ready, 1);
`ifdef STREAM_RX_CHECK_EN
      checkOutput({tag, "_crc_err"}, crc_err, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      stream.delete();
      expq.delete();
      phase = 0;
      expFrames = 8'h00;
      crcExp = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      phase = 0;
      expFrames = 8'h00;
      crcExp = 1'b0;
      repeat (2) @(posedge clk);
      doReset("reset");

      // Basic decrypt: A5,00,00,1E,70 -> FF,00 (check mode: 1E,8F -> FF only)
      emitted.delete();
      addFrame(16'h0000, 0, 8'h1E, 8'h70, 1'b0, 8'h00);
      runUntilIdle(50, 1'b0);
      checkOutput("basic_count", emitted.size(), DATA_N);
      if (emitted.size() > 0) checkOutput("basic_b0", emitted[0], 8'hFF);
      if (emitted.size() > 1) checkOutput("basic_b1", emitted[1], 8'h00);
      checkOutput("basic_frames", frame_cnt, 1);

      // Zero seed: IV equal to KEY forces seed 0001, so 01 decrypts to 00
      emitted.delete();
      addFrame(KEY, 0, 8'h01, 8'h5A, 1'b0, 8'h00);
      runUntilIdle(50, 1'b0);
      if (emitted.size() > 0) checkOutput("zseed_b0", emitted[0], 8'h00);

      // Hunt filtering: leading 00,3C are discarded
      emitted.delete();
      pushEnt(8'h00, K_JUNK, 8'h00, 1'b0, 1'b0, 1'b0);
      pushEnt(8'h3C, K_JUNK, 8'h00, 1'b0, 1'b0, 1'b0);
      addFrame(16'h0000, 0, 8'h1E, 8'h70, 1'b0, 8'h00);
      runUntilIdle(50, 1'b0);
      checkOutput("hunt_count", emitted.size(), DATA_N);
      if (emitted.size() > 0) checkOutput("hunt_b0", emitted[0], 8'hFF);

      // Backpressure: hold FF for 5 cycles with in_ready low
      emitted.delete();
      addFrame(16'h0000, 0, 8'h1E, 8'h70, 1'b0, 8'h00);
      n = 0;
      while (expq.size() == 0 && n < 20) begin
         applyStimulus(1'b1, 0);
         n++;
      end
      repeat (5) begin
         applyStimulus(1'b0, 0);
         checkOutput("bp_hold_data", out_data, 8'hFF);
         checkOutput("bp_in_ready", in_ready, 0);
      end
      runUntilIdle(50, 1'b0);
      checkOutput("bp_count", emitted.size(), DATA_N);
      if (emitted.size() > 0) checkOutput("bp_b0", emitted[0], 8'hFF);
      if (emitted.size() > 1) checkOutput("bp_b1", emitted[1], 8'h00);

      // Mid-frame reset with a plaintext byte pending, then a clean frame
      addFrame(16'h0000, 0, 8'h1E, 8'h70, 1'b0, 8'h00);
      n = 0;
      while (expq.size() == 0 && n < 20) begin
         applyStimulus(1'b0, 0);
         n++;
      end
      doReset("midrst");
      emitted.delete();
      addFrame(16'h0000, 0, 8'h1E, 8'h70, 1'b0, 8'h00);
      runUntilIdle(50, 1'b0);
      if (emitted.size() > 0) checkOutput("midrst_b0", emitted[0], 8'hFF);
      checkOutput("midrst_frames", frame_cnt, 1);

`ifdef STREAM_RX_CHECK_EN
      // Corrupted check byte 8E: crc_err pulse is checked cycle by cycle in monitor
      emitted.delete();
      addFrame(16'h0000, 0, 8'h1E, 8'h00, 1'b0, 8'h01);
      runUntilIdle(50, 1'b0);
      if (emitted.size() > 0) checkOutput("crc_b0", emitted[0], 8'hFF);
`endif

      // Randomized frames in batches so HUNT overlaps a pending last byte; frame_cnt wraps
      for (int batch = 0; batch < 60; batch++) begin
         for (int f = 0; f < 5; f++) begin
            addFrame(($urandom_range(7) == 0) ? KEY : 16'($urandom_range(65535)),
                     int'($urandom_range(2)), 8'h00, 8'h00, 1'b1,
                     ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
         end
         runUntilIdle(500, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish (bad=%0d)", badChecks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
